fir_job_ctrl: RTL
=================

Name: fir_job_ctrl

Overview:
- Job sequencer for the shared-memory FIR datapath (operation-coded load/compute/read port).
- Accepts one start, clears the FIR, and streams SIG_LEN input samples into it.
- Runs the compute phase until the datapath reports done, then streams SIG_LEN results out over valid/ready.
- Sits between the RNS/DSP stream fabric and the FIR core; the FIR core needs no other master.

Parameters:
- N, 100, FIR tap count; used only for the watchdog bound.
- SIG_LEN, 1000, samples per job, both in and out.
- CNT_W, 32, width of the load/read counters and of fir_addr.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  job request; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse when the last output is accepted
- error  out  1  sticky watchdog flag; constant 0 without the optional feature
- in_valid  in  1  input sample valid
- in_ready  out  1  high in LOAD only
- in_data  in  32  input sample
- out_valid  out  1  high in OUT only
- out_ready  in  1  output accept
- out_data  out  32  result; equals fir_y
- fir_reset  out  1  FIR clear pulse
- fir_op  out  2  00 idle, 01 write, 10 compute, 11 read
- fir_addr  out  CNT_W  sample/result index
- fir_x  out  32  write data; equals in_data
- fir_y  in  32  FIR read data, registered one cycle after op 11
- fir_done  in  1  FIR compute-complete flag

Behaviour:
- Reset values: state IDLE, counters 0, error 0. All outputs 0 except out_data, which follows fir_y. Reset wins over start and over any handshake in the same cycle. Reset mid-job aborts to IDLE with no job_done and no further FIR traffic.
- State machine:
  - IDLE: start=1 -> CLEAR.
  - CLEAR (1 cycle): fir_reset=1, fir_op=00, load_cnt cleared -> LOAD.
  - LOAD: in_ready=1. fir_op=01 when in_valid=1, otherwise 00. fir_addr=load_cnt; fir_x=in_data, combinational. Each handshake increments load_cnt. Handshake with load_cnt==SIG_LEN-1 -> RUN. in_valid low stalls indefinitely.
  - RUN: fir_op=10, fir_addr=0. fir_done=1 sampled -> RD_REQ with rd_cnt=0; fir_op=10 is not driven in the exit cycle.
  - RD_REQ (1 cycle): fir_op=11, fir_addr=rd_cnt -> OUT.
  - OUT: fir_op=00, out_valid=1, out_data=fir_y.
    - out_ready=0: hold; out_data stays stable because the FIR holds y.
    - Handshake with rd_cnt<SIG_LEN-1: rd_cnt+1 -> RD_REQ.
    - Handshake with rd_cnt==SIG_LEN-1: job_done pulse -> IDLE.
- Throughput: load 1 sample/cycle; drain 1 result per 2 cycles when out_ready is held high.
- First out_valid comes exactly 2 cycles after RUN exits.
- start while busy=1 is ignored, not queued.
- fir_done=1 arriving before RUN (stale flag) is ignored; CLEAR guarantees it is 0 on RUN entry.
- Counters never wrap; SIG_LEN must be ≤ 2^CNT_W−1.

Optional Feature:
- Macro FIR_JOB_CTRL_WATCHDOG_EN.
- With the macro:
  - A RUN-cycle counter starts at 0 on RUN entry.
  - Reaching SIG_LEN*(N+1)+8 without fir_done -> state ERR: fir_op=00, error=1 (sticky), busy=1.
  - ERR leaves only via reset.
- Without the macro: no counter, no ERR state, error tied to 0, RUN waits forever.

Decomposition:
- Shared package fir_pkg:
  - typedef fir_op_e {FIR_NOP=2'b00, FIR_WR=2'b01, FIR_RUN=2'b10, FIR_RD=2'b11}.
  - typedef ctrl_state_e.
  - Sample width constant FIR_DW=32.
- Single module; no natural sub-module. The FSM plus two counters (and the optional watchdog) is the whole block.

Test Plan:
- Impulse job: N=4, SIG_LEN=8, coefficients 1,2,3,4, input 1,0,0,0,0,0,0,0. Required: busy rises on start; exactly 8 op-01 writes at addr 0..7; outputs in the FIR core's documented coefficient order (1,2,3,4 then zeros, per the core's indexing); one job_done pulse; busy=0 the next cycle.
- Back-pressure: same job with out_ready toggling 1-of-3 cycles. Required: out_data stable while out_valid=1 and out_ready=0; no result dropped or duplicated.
- Input stall: in_valid low for 5 cycles after sample 3. Required: fir_op=00 during the gap; load_cnt holds at 3; the remaining writes use addrs 3..7.
- start pulsed during RUN and during OUT. Required: ignored, no CLEAR pulse; the next start after job_done runs a fresh job, and a stale fir_done does not skip RUN.
- Reset asserted in LOAD after 4 samples, together with start. Required: next cycle IDLE, all outputs 0, no job_done; a subsequent job runs correctly.
- Macro on, FIR model holding fir_done=0: after 8*5+8=48 RUN cycles, error=1 and fir_op=00 persist until reset. Macro off: error stays 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the FIR job sequencer: FIR port operation codes,
// controller states and the sample width.
package fir_pkg;

    localparam int FIR_DW = 32;

    typedef enum logic [1:0] {
        FIR_NOP = 2'b00,
        FIR_WR  = 2'b01,
        FIR_RUN = 2'b10,
        FIR_RD  = 2'b11
    } fir_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_RD_REQ = 3'd4,
        ST_OUT    = 3'd5,
        ST_ERR    = 3'd6
    } ctrl_state_e;

endpackage

// File: rtl/fir_job_ctrl_if.sv
// Signal bundle between the job sequencer (master) and its environment
// (slave): job control, input/output sample streams and the FIR core port.
interface fir_job_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import fir_pkg::*;

    // Streams: a transfer happens on a rising clock edge where valid and ready
    // are both high; valid never waits on ready, data is held while valid&&!ready.
    logic              start;
    logic              busy;
    logic              job_done;
    logic              error;
    logic              in_valid;
    logic              in_ready;
    logic [FIR_DW-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [FIR_DW-1:0] out_data;
    logic              fir_reset;
    logic [1:0]        fir_op;
    logic [CNT_W-1:0]  fir_addr;
    logic [FIR_DW-1:0] fir_x;
    logic [FIR_DW-1:0] fir_y;
    logic              fir_done;

    modport master (
        input  start, in_valid, in_data, out_ready, fir_y, fir_done,
        output busy, job_done, error, in_ready, out_valid, out_data,
               fir_reset, fir_op, fir_addr, fir_x
    );

    modport slave (
        output start, in_valid, in_data, out_ready, fir_y, fir_done,
        input  busy, job_done, error, in_ready, out_valid, out_data,
               fir_reset, fir_op, fir_addr, fir_x
    );

endinterface

// File: rtl/fir_job_ctrl.sv
// Job sequencer for the shared-memory FIR core: clear, load SIG_LEN samples,
// compute until done, then drain SIG_LEN results. Optional RUN watchdog: FIR_JOB_CTRL_WATCHDOG_EN.
module fir_job_ctrl
    import fir_pkg::*;
#(
    parameter int N       = 100,
    parameter int SIG_LEN = 1000,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    fir_job_ctrl_if.master bus,
    output ctrl_state_e  dbg_state_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIG_LEN - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             busy_q, in_ready_q, out_valid_q, fir_reset_q;

`ifdef FIR_JOB_CTRL_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(SIG_LEN * (N + 1) + 8 - 1);
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        error_q;
`endif

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        rd_cnt_d   = rd_cnt_q;
`ifdef FIR_JOB_CTRL_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                load_cnt_d = '0;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                    if (load_cnt_q == LAST) begin
                        state_d = ST_RUN;
`ifdef FIR_JOB_CTRL_WATCHDOG_EN
                        wd_cnt_d = '0;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (bus.fir_done) begin
                    rd_cnt_d = '0;
                    state_d  = ST_RD_REQ;
                end
`ifdef FIR_JOB_CTRL_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
`endif
            end
            ST_RD_REQ: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    if (rd_cnt_q == LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                        state_d  = ST_RD_REQ;
                    end
                end
            end
`ifdef FIR_JOB_CTRL_WATCHDOG_EN
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they are registered
    // and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            fir_reset_q <= 1'b0;
`ifdef FIR_JOB_CTRL_WATCHDOG_EN
            wd_cnt_q    <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            busy_q      <= (state_d != ST_IDLE);
            in_ready_q  <= (state_d == ST_LOAD);
            out_valid_q <= (state_d == ST_OUT);
            fir_reset_q <= (state_d == ST_CLEAR);
`ifdef FIR_JOB_CTRL_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            error_q     <= (state_d == ST_ERR);
`endif
        end
    end

    // The FIR op follows the live handshake: no write without in_valid, and
    // compute is dropped in the cycle fir_done is seen.
    always_comb begin
        bus.fir_op   = FIR_NOP;
        bus.fir_addr = '0;
        case (state_q)
            ST_LOAD: begin
                bus.fir_op   = bus.in_valid ? FIR_WR : FIR_NOP;
                bus.fir_addr = load_cnt_q;
            end
            ST_RUN: begin
                bus.fir_op = bus.fir_done ? FIR_NOP : FIR_RUN;
            end
            ST_RD_REQ: begin
                bus.fir_op   = FIR_RD;
                bus.fir_addr = rd_cnt_q;
            end
            default: ;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fir_reset = fir_reset_q;
    assign bus.fir_x     = (state_q == ST_LOAD) ? bus.in_data : '0;
    assign bus.out_data  = bus.fir_y;
    assign bus.job_done  = (state_q == ST_OUT) && bus.out_ready && (rd_cnt_q == LAST);
    assign dbg_state_o   = state_q;

`ifdef FIR_JOB_CTRL_WATCHDOG_EN
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule
